pipe_control: RTL and testbench
===============================

// Module: pipe_control
// PURPOSE
//  Pipelined successor to the single-cycle opcode decoder: decodes full RV32I base opcodes in ID and
//  carries control bits through EX, MEM and WB pipeline registers with valid tracking.
//  Detects load-use hazards and inserts bubbles, honours external stalls and branch flushes,
//  flags illegal opcodes and counts stall cycles. Sits between instruction fetch/ID and the datapath.
// PARAMETERS
//  REG_ADDR_W  5   register index width (rd/rs1/rs2)
//  CNT_W      16   width of saturating stall-cycle counter
//  HAZARD_EN   1   1: load-use detection active; 0: hazard_stall tied 0 (compiler-scheduled code)
// PORTS
//  clk          in   1           system clock, all state on rising edge
//  rst_n        in   1           asynchronous active-low reset
//  in_valid     in   1           ID holds an instruction
//  opcode       in   7           instruction[6:0]
//  rd,rs1,rs2   in   REG_ADDR_W  register fields of ID instruction
//  stall_ext    in   1           memory/fetch stall: freeze all stages
//  flush        in   1           branch/jump taken in EX: kill ID instruction
//  in_ready     out  1           ID instruction accepted this cycle
//  hazard_stall out  1           load-use bubble inserted this cycle (combinational)
//  ex_valid     out  1           EX stage occupied
//  ex_alu_src   out  1           0: rs2, 1: immediate
//  ex_alu_op    out  2           00 add(ld/st/jal/jalr/auipc), 01 branch cmp, 10 R-type, 11 I-type
//  ex_branch    out  1           conditional branch in EX
//  ex_jump      out  2           00 none, 01 jal, 10 jalr
//  mem_read     out  1           load in MEM (gated by MEM valid)
//  mem_write    out  1           store in MEM (gated by MEM valid)
//  wb_reg_write out  1           write-back enable (gated by WB valid, forced 0 if wb_rd==0)
//  wb_mem_to_reg out 2           00 ALU, 01 memory, 10 PC+4, 11 immediate (lui)
//  wb_rd        out  REG_ADDR_W  destination register in WB
//  illegal      out  1           one-cycle pulse: illegal opcode entered EX
//  stall_cnt    out  CNT_W       cycles with hazard_stall or stall_ext, saturating
// BEHAVIOUR
//  Reset: all stage valids, every control output, wb_rd, illegal, stall_cnt = 0.
//  Decode (ID, combinational) then registered; latency ID->EX 1 clk, ->MEM 2, ->WB 3.
//   R 0110011: alu_src0 op10 rw1 m2r00 | I 0010011: alu_src1 op11 rw1 m2r00
//   L 0000011: alu_src1 op00 rd1 rw1 m2r01 | S 0100011: alu_src1 op00 wr1 rw0
//   B 1100011: alu_src0 op01 br1 rw0 | JAL 1101111: jump01 rw1 m2r10
//   JALR 1100111: alu_src1 op00 jump10 rw1 m2r10 | LUI 0110111: rw1 m2r11 | AUIPC 0010111: alu_src1 op00 rw1 m2r00
//   Other: illegal; enters EX as valid NOP (all writes/branch/jump 0), illegal=1 for that cycle.
//  Hazard (HAZARD_EN=1): hazard_stall = in_valid & ex_valid & EX is load & ex_rd!=0 &
//   (ex_rd==rs1 | (ex_rd==rs2 & opcode in {R,S,B})). rs1 ignored for JAL/LUI/AUIPC.
//  Priority per cycle: stall_ext > flush > hazard_stall > normal advance.
//   stall_ext=1: EX/MEM/WB hold; in_ready=0 unless flush=1 (ID killed, in_ready=1, EX holds).
//   flush=1 (no stall_ext): EX<-bubble, ID instr discarded, in_ready=1, MEM/WB advance; hazard ignored.
//   hazard_stall=1: EX<-bubble, MEM/WB advance, in_ready=0; ID re-presented next cycle.
//   normal: in_ready=1; EX<-decoded ID (valid=in_valid), MEM<-EX, WB<-MEM.
//  Bubble = valid 0, all control 0. Outputs never assert for invalid stages.
//  stall_cnt += 1 when (hazard_stall|stall_ext), holds at 2^CNT_W-1.
//  Reset mid-operation: all in-flight instructions dropped, no partial write-back.
// TESTING
//  Reset: rst_n=0 mid-stream -> all outputs 0 same cycle (async), stall_cnt=0.
//  lw x5 then add x6,x5,x1 back-to-back -> hazard_stall=1 one cycle, in_ready=0, add reaches EX 1 clk late.
//  lw x0 then add x6,x0,x1 -> no stall; lw x5 then jal x1 -> no stall.
//  beq in EX with flush=1 and sw in ID -> sw never asserts mem_write, in_ready=1.
//  stall_ext=1 for 3 clk during sw in MEM -> mem_write held 3 clk, stall_cnt=3.
//  opcode 1111111 -> illegal pulses 1 clk, 3 clk later wb_reg_write=0; lui x7 -> wb_mem_to_reg=11, wb_rd=7.

Source files
------------

// File: rtl/pipe_control.sv
// Pipeline control: RV32I opcode decode in ID, control bits carried through EX/MEM/WB,
// load-use bubbles, external stall, branch flush, illegal flag and a saturating stall counter.
// Ports: clk, rst_n, in_valid, opcode, rd/rs1/rs2, stall_ext, flush -> in_ready, hazard_stall,
// ex_* (EX controls), mem_read/mem_write, wb_* (write-back), illegal, stall_cnt.
module pipe_control #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16,
  parameter int HAZARD_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  stall_ext,
  input  logic                  flush,
  output logic                  in_ready,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_branch,
  output logic [1:0]            ex_jump,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  illegal,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic [1:0] jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] m2r;
  } ctrl_t;

  ctrl_t dec;
  logic  dec_ill;
  logic  uses_rs1;
  logic  uses_rs2;

  always_comb begin
    dec      = '0;
    dec_ill  = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        dec.alu_op    = 2'b10;
        dec.reg_write = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_I: begin
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b11;
        dec.reg_write = 1'b1;
      end
      OP_L: begin
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.m2r       = 2'b01;
      end
      OP_S: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_B: begin
        dec.alu_op = 2'b01;
        dec.branch = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_JAL: begin
        dec.jump      = 2'b01;
        dec.reg_write = 1'b1;
        dec.m2r       = 2'b10;
        uses_rs1      = 1'b0;
      end
      OP_JALR: begin
        dec.alu_src   = 1'b1;
        dec.jump      = 2'b10;
        dec.reg_write = 1'b1;
        dec.m2r       = 2'b10;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.m2r       = 2'b11;
        uses_rs1      = 1'b0;
      end
      OP_AUIPC: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        uses_rs1      = 1'b0;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  ctrl_t                 ex_c;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_valid;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic                  mem_rw_q;
  logic [1:0]            mem_m2r_q;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic                  wb_valid;
  logic                  wb_rw_q;
  logic [1:0]            wb_m2r_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic                  illegal_q;

  logic haz_raw;
  logic take;

  // rs2 only matters for formats that actually read it
  assign haz_raw = in_valid & ex_valid & ex_c.mem_read &
                   (ex_rd != '0) &
                   (((ex_rd == rs1) & uses_rs1) |
                    ((ex_rd == rs2) & uses_rs2));

  // a stall or flush this cycle overrides the load-use bubble
  assign hazard_stall = (HAZARD_EN != 0) & haz_raw &
                        ~stall_ext & ~flush;

  assign in_ready = rst_n &
                    (stall_ext ? flush : ~hazard_stall);

  assign take = ~stall_ext & ~flush &
                ~hazard_stall & in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_c        <= '0;
      ex_rd       <= '0;
      mem_valid   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_m2r_q   <= '0;
      mem_rd_addr <= '0;
      wb_valid    <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_m2r_q    <= '0;
      wb_rd_q     <= '0;
      illegal_q   <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      illegal_q <= 1'b0;
      if (!stall_ext) begin
        wb_valid    <= mem_valid;
        wb_rw_q     <= mem_rw_q;
        wb_m2r_q    <= mem_m2r_q;
        wb_rd_q     <= mem_rd_addr;
        mem_valid   <= ex_valid;
        mem_rd_q    <= ex_c.mem_read;
        mem_wr_q    <= ex_c.mem_write;
        mem_rw_q    <= ex_c.reg_write;
        mem_m2r_q   <= ex_c.m2r;
        mem_rd_addr <= ex_rd;
        if (take) begin
          ex_valid  <= 1'b1;
          ex_c      <= dec;
          ex_rd     <= dec_ill ? '0 : rd;
          illegal_q <= dec_ill;
        end else begin
          ex_valid <= 1'b0;
          ex_c     <= '0;
          ex_rd    <= '0;
        end
      end
      if ((hazard_stall | stall_ext) &&
          (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_alu_src    = ex_valid & ex_c.alu_src;
  assign ex_alu_op     = {2{ex_valid}} & ex_c.alu_op;
  assign ex_branch     = ex_valid & ex_c.branch;
  assign ex_jump       = {2{ex_valid}} & ex_c.jump;
  assign mem_read      = mem_valid & mem_rd_q;
  assign mem_write     = mem_valid & mem_wr_q;
  assign wb_reg_write  = wb_valid & wb_rw_q & (wb_rd_q != '0);
  assign wb_mem_to_reg = {2{wb_valid}} & wb_m2r_q;
  assign wb_rd         = {REG_ADDR_W{wb_valid}} & wb_rd_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: per-cycle vector table for decode/pipelining
// plus hand sequences for hazards, flush, external stall, saturation and reset.
module tb_pipe_control;

  localparam int CW = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2;
  logic          stall_ext, flush;
  logic          in_ready, hazard_stall;
  logic          ex_valid, ex_alu_src, ex_branch;
  logic [1:0]    ex_alu_op, ex_jump;
  logic          mem_read, mem_write;
  logic          wb_reg_write;
  logic [1:0]    wb_mem_to_reg;
  logic [4:0]    wb_rd;
  logic          illegal;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_control #(.REG_ADDR_W(5), .CNT_W(CW), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .stall_ext(stall_ext), .flush(flush),
    .in_ready(in_ready), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       rdy, haz, exv, src;
    logic [1:0] aop;
    logic       br;
    logic [1:0] jmp;
    logic       mr, mw, rw;
    logic [1:0] m2r;
    logic [4:0] wrd;
    logic       ill;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t v(int iv, logic [6:0] op, int d, int s1, int s2,
                             int rdy, int haz, int exv, int src, int aop,
                             int br, int jmp, int mr, int mw, int rw,
                             int m2r, int wrd, int ill);
    vec_t r;
    r.iv = 1'(iv); r.op = op; r.rd = 5'(d); r.rs1 = 5'(s1); r.rs2 = 5'(s2);
    r.rdy = 1'(rdy); r.haz = 1'(haz); r.exv = 1'(exv); r.src = 1'(src);
    r.aop = 2'(aop); r.br = 1'(br); r.jmp = 2'(jmp); r.mr = 1'(mr);
    r.mw = 1'(mw); r.rw = 1'(rw); r.m2r = 2'(m2r); r.wrd = 5'(wrd);
    r.ill = 1'(ill);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic iv, logic [6:0] op, logic [4:0] d,
                       logic [4:0] s1, logic [4:0] s2, logic se, logic fl);
    in_valid = iv; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    stall_ext = se; flush = fl;
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    stall_ext = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  function automatic logic [19:0] act_vec();
    return {in_ready, hazard_stall, ex_valid, ex_alu_src, ex_alu_op,
            ex_branch, ex_jump, mem_read, mem_write, wb_reg_write,
            wb_mem_to_reg, wb_rd, illegal};
  endfunction

  function automatic logic [19:0] exp_vec(vec_t t);
    return {t.rdy, t.haz, t.exv, t.src, t.aop, t.br, t.jmp, t.mr, t.mw,
            t.rw, t.m2r, t.wrd, t.ill};
  endfunction

  logic [31:0] all_out;

  initial begin
    //             iv op        rd s1 s2 | rdy hz exv src aop br jmp mr mw rw m2r wrd ill
    tbl[0]  = v(1, OP_R,     1, 2, 3,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, OP_I,     2, 3, 0,   1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(1, OP_L,     3, 4, 0,   1, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = v(1, OP_S,     0, 5, 6,   1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[4]  = v(1, OP_B,     0, 7, 8,   1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 2, 0);
    tbl[5]  = v(1, OP_JAL,   1, 0, 0,   1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 3, 0);
    tbl[6]  = v(1, OP_JALR,  2, 9, 0,   1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = v(1, OP_LUI,   7, 0, 0,   1, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    tbl[8]  = v(1, OP_AUIPC, 4, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0);
    tbl[9]  = v(1, OP_BAD,   5, 0, 0,   1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 2, 0);
    tbl[10] = v(0, 7'd0,     0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 7, 1);
    tbl[11] = v(0, 7'd0,     0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0);
    tbl[12] = v(0, 7'd0,     0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = v(0, 7'd0,     0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // power-on reset: everything low, including in_ready
    rst_n = 1'b0;
    in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    stall_ext = 1'b0; flush = 1'b0;
    #2;
    all_out = 32'(act_vec());
    chk("reset_outputs", all_out, 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);

    // decode + pipeline table
    do_reset;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            1'b0, 1'b0);
      chk($sformatf("table_row%0d", i), 32'(act_vec()), 32'(exp_vec(tbl[i])));
      tick;
    end
    chk("table_no_stalls", 32'(stall_cnt), 32'd0);

    // load-use on rs1: lw x5 ; add x6,x5,x1
    do_reset;
    drive(1'b1, OP_L, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
    chk("lu_first_ready", 32'(in_ready), 32'd1);
    tick;
    drive(1'b1, OP_R, 5'd6, 5'd5, 5'd1, 1'b0, 1'b0);
    chk("lu_hazard", 32'(hazard_stall), 32'd1);
    chk("lu_not_ready", 32'(in_ready), 32'd0);
    tick;
    drive(1'b1, OP_R, 5'd6, 5'd5, 5'd1, 1'b0, 1'b0);
    chk("lu_hazard_gone", 32'(hazard_stall), 32'd0);
    chk("lu_ready_again", 32'(in_ready), 32'd1);
    chk("lu_bubble_in_ex", 32'(ex_valid), 32'd0);
    chk("lu_load_in_mem", 32'(mem_read), 32'd1);
    tick;
    idle;
    chk("lu_add_in_ex", 32'({ex_valid, ex_alu_op}), 32'({1'b1, 2'b10}));
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    tick;

    // load-use on rs2 of a store
    drive(1'b1, OP_L, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
    tick;
    drive(1'b1, OP_S, 5'd0, 5'd2, 5'd5, 1'b0, 1'b0);
    chk("lu_rs2_store", 32'(hazard_stall), 32'd1);
    tick;
    // I-type rs2 field is immediate bits: no stall
    drive(1'b1, OP_L, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
    tick;
    drive(1'b1, OP_I, 5'd9, 5'd2, 5'd5, 1'b0, 1'b0);
    chk("no_hz_itype_rs2", 32'(hazard_stall), 32'd0);
    tick;
    // lw x0 ; add x6,x0,x1
    drive(1'b1, OP_L, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0);
    tick;
    drive(1'b1, OP_R, 5'd6, 5'd0, 5'd1, 1'b0, 1'b0);
    chk("no_hz_x0", 32'(hazard_stall), 32'd0);
    tick;
    // lw x5 ; jal x1 (rs1 field happens to be 5)
    drive(1'b1, OP_L, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
    tick;
    drive(1'b1, OP_JAL, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0);
    chk("no_hz_jal", 32'(hazard_stall), 32'd0);
    chk("jal_ready", 32'(in_ready), 32'd1);
    tick;
    idle;
    chk("hz_cnt_total", 32'(stall_cnt), 32'd2);

    // beq in EX, flush with sw in ID
    do_reset;
    drive(1'b1, OP_B, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    tick;
    drive(1'b1, OP_S, 5'd0, 5'd3, 5'd4, 1'b0, 1'b1);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_branch_ex", 32'(ex_branch), 32'd1);
    tick;
    idle;
    chk("flush_ex_empty", 32'(ex_valid), 32'd0);
    chk("flush_memw_1", 32'(mem_write), 32'd0);
    tick;
    chk("flush_memw_2", 32'(mem_write), 32'd0);
    tick;

    // stall_ext 3 clk with sw in MEM
    do_reset;
    drive(1'b1, OP_S, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    tick;
    idle;
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_R, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0);
      chk($sformatf("stall_memw_%0d", i), 32'(mem_write), 32'd1);
      chk($sformatf("stall_noready_%0d", i), 32'(in_ready), 32'd0);
      tick;
    end
    idle;
    chk("stall_memw_after", 32'(mem_write), 32'd1);
    chk("stall_cnt3", 32'(stall_cnt), 32'd3);
    tick;
    chk("stall_memw_drained", 32'(mem_write), 32'd0);
    drive(1'b1, OP_R, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);
    chk("stall_flush_ready", 32'(in_ready), 32'd1);
    tick;

    // illegal pulse, then lui x7 through WB
    do_reset;
    drive(1'b1, OP_BAD, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    tick;
    drive(1'b1, OP_LUI, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("ill_pulse", 32'(illegal), 32'd1);
    tick;
    idle;
    chk("ill_pulse_end", 32'(illegal), 32'd0);
    tick;
    chk("ill_wb_noreg", 32'(wb_reg_write), 32'd0);
    tick;
    chk("lui_wb", 32'({wb_reg_write, wb_mem_to_reg, wb_rd}),
        32'({1'b1, 2'b11, 5'd7}));
    tick;

    // counter saturates
    do_reset;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      tick;
    end
    chk("cnt_saturate", 32'(stall_cnt), 32'd15);

    // async reset mid-stream
    drive(1'b1, OP_LUI, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    tick;
    drive(1'b1, OP_R, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0);
    tick;
    chk("pre_reset_busy", 32'(ex_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'(act_vec()), 32'd0);
    chk("midreset_cnt", 32'(stall_cnt), 32'd0);
    tick;
    rst_n = 1'b1;
    idle;
    tick;
    tick;
    tick;
    chk("no_wb_after_reset", 32'(wb_reg_write), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
